regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
// - Parametrised multi-port integer register file with a per-register busy scoreboard.
// - Successor to the fixed 32x32, 2-read/1-write register file: width, depth and read-port count are parametrised.
// - Adds pending-write tracking so the decode stage can detect RAW hazards. Sits between decode (read/alloc) and writeback (write).
// PARAMETERS
// - XLEN      32  data width of every register
// - NREG      32  number of registers (power of 2, >=2); register 0 hardwired to zero
// - NREAD      2  number of independent read ports (1..4)
// - AW        $clog2(NREG)  address width (derived, do not override)
// PORTS
// - clk         in   1           rising-edge clock
// - rst_n       in   1           asynchronous active-low reset
// - rd_addr     in   NREAD*AW    packed read addresses, port i at [i*AW +: AW]
// - rd_data     out  NREAD*XLEN  packed read data, port i at [i*XLEN +: XLEN]
// - rd_busy     out  NREAD       1 = register on port i has an outstanding write
// - wr_en       in   1           writeback strobe
// - wr_addr     in   AW          writeback address
// - wr_data     in   XLEN        writeback data
// - alloc_en    in   1           decode reserves a destination register
// - alloc_addr  in   AW          register being reserved
// - flush       in   1           clear all busy bits (pipeline squash)
// - busy_vec    out  NREG        registered scoreboard state, bit r = register r busy
// BEHAVIOUR
// - Reset (rst_n=0, async): all registers 0, all busy bits 0; rd_data=0, rd_busy=0, busy_vec=0 while held.
// - Reads are combinational: rd_data/rd_busy follow rd_addr in the same cycle, with no clock needed.
// - Write: when wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data at the rising edge. The write is visible via storage from the next cycle.
// - Register 0: writes are ignored; reads always return 0 with rd_busy=0; alloc to 0 is ignored; busy_vec[0] is always 0.
// - Scoreboard update at each edge, in priority order:
//   - flush=1 -> all busy bits <= 0; same-cycle alloc is ignored. The same-cycle write still updates data.
//   - else if alloc_en and alloc_addr==wr_addr with wr_en -> busy stays/becomes 1 (the new producer wins).
//   - else alloc_en sets busy[alloc_addr]; wr_en clears busy[wr_addr].
// - A write to a non-busy register is legal: data is updated and busy stays 0.
// - Re-alloc of an already-busy register is legal: the bit stays 1 and there is no counting.
// - Read ports are fully independent: any ports may share an address, and each gets the identical result.
// - rd_busy[i] = busy[rd_addr_i], subject to the bypass rule below.
// - No internal FSM beyond the scoreboard: one-cycle write latency, zero-cycle read latency.
// CONFIGURATION
// - REGFILE_BYPASS_EN defined: write-through forwarding.
//   - Applies to any port with rd_addr_i==wr_addr, wr_en=1 and wr_addr!=0.
//   - rd_data_i = wr_data and rd_busy_i = 0 in the same cycle.
//   - The bypass overrides a same-cycle alloc of that address for the read result only.
// - REGFILE_BYPASS_EN undefined: reads return storage only.
//   - The old value and old busy bit are seen during the write cycle; the new value is seen from the next cycle.
// TESTING
// - T1 reset: write reg5=0x11, then assert rst_n=0 mid-cycle -> rd_data(5)=0 and busy_vec=0 immediately, without waiting for a clock edge.
// - T2 write/read isolation: write r1=0xDEADBEEF, r2=0x12345678.
//   - Next cycle, port0=r2 and port1=r1 -> 0x12345678 and 0xDEADBEEF.
//   - Unwritten r3 -> 0.
// - T3 zero register: wr r0=0x98761234 and alloc r0 -> all ports reading r0 give 0 and rd_busy=0; busy_vec[0]=0.
// - T4 bypass: wr r4=0x76767676 while all ports read r4.
//   - With REGFILE_BYPASS_EN: 0x76767676 in the same cycle.
//   - Without: old value (0) that cycle, 0x76767676 the next cycle.
// - T5 scoreboard: alloc r7 -> rd_busy=1 and busy_vec[7]=1.
//   - Write r7=0xA5 -> busy clears after the edge.
//   - Alloc r7 and write r7 in the same cycle -> busy_vec[7] stays 1 and data=new value.
// - T6 flush: alloc r8, r9, r10 on successive cycles, then flush together with alloc r11 -> busy_vec=0 next cycle (r11 not set).
// - All tests run with NREAD=2 and NREAD=4 and with XLEN=32 and XLEN=64.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised multi-read-port register file with a per-register pending-write scoreboard.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_addr,
    input  logic                  flush,
    output logic [NREG-1:0]       busy_vec
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Alloc is applied after the writeback clear so a same-cycle new producer keeps the bit set.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (wr_en) begin
                busy_next[wr_addr] = 1'b0;
            end
            if (alloc_en) begin
                busy_next[alloc_addr] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_vec = busy;

    always_comb begin
        logic [AW-1:0] a;
        a       = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            a = rd_addr[i*AW +: AW];
            if (a != '0) begin
                rd_data[i*XLEN +: XLEN] = regs[a];
                rd_busy[i]              = busy[a];
`ifdef REGFILE_BYPASS_EN
                // Forwarding is held off during reset so outputs read as zero.
                if (rst_n && wr_en && (wr_addr == a)) begin
                    rd_data[i*XLEN +: XLEN] = wr_data;
                    rd_busy[i]              = 1'b0;
                end
`endif
            end
        end
    end

endmodule
